// File: rtl/key_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, 4-state debounce FSM, press/release
// strobes, a toggle level and a one-shot long-press strobe, all registered.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int CNT_W           = 29
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic KEY,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  // The sample that enters a WAIT state is the first stable one, so the window
  // closes when the count already holds DEBOUNCE_CYCLES-1 stable samples.
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_CYCLES);

  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             toggle_q, toggle_d;
  logic             long_press_q, long_press_d;
  logic             k_s;

  assign k_s = sync2_q;

  // NOTE: every next-state signal gets a default before the case, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    toggle_d        = toggle_q;
    long_press_d    = 1'b0;

    if (pressed_q) begin
      if (hold_cnt_q < HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + CNT_ONE;
      end else if (hold_cnt_q == HOLD_LAST) begin
        hold_cnt_d   = HOLD_SAT;
        long_press_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!k_s) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (k_s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
          state_d       = PRESSED;
          db_cnt_d      = '0;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
          toggle_d      = ~toggle_q;
          hold_cnt_d    = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (k_s) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!k_s) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
          state_d         = IDLE;
          db_cnt_d        = '0;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
          hold_cnt_d      = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      state_q         <= IDLE;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      toggle_q        <= 1'b0;
      long_press_q    <= 1'b0;
    end else begin
      sync1_q         <= KEY;
      sync2_q         <= sync1_q;
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      toggle_q        <= toggle_d;
      long_press_q    <= long_press_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign toggle        = toggle_q;
  assign long_press    = long_press_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: a per-cycle expectation queue filled by the stimulus
// side from a run-length reference model, drained by an independent monitor.
module tb_key_debouncer;

  localparam int D = 4;
  localparam int H = 20;
  localparam int W = 8;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;
  logic KEY      = 1'b1;
  logic pressed, press_pulse, release_pulse, toggle, long_press;

  key_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .CNT_W          (W)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .KEY          (KEY),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .toggle       (toggle),
    .long_press   (long_press)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // vec = {pressed, toggle, press_pulse, release_pulse, long_press}
  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  exp_t sb_q[$];
  logic toggle_log[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_press = 0, n_release = 0, n_long = 0;
  int   last_press_cyc = -1, last_release_cyc = -1, last_long_cyc = -1;

  // Reference model: a two-sample delay, then a run of D consecutive samples
  // opposite to the accepted level flips it; held cycles are counted to H.
  bit m_d1, m_d2, m_level, m_toggle;
  int m_run, m_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_d1     = 1'b1;
    m_d2     = 1'b1;
    m_level  = 1'b0;
    m_toggle = 1'b0;
    m_run    = 0;
    m_held   = 0;
  endfunction

  function automatic void model_edge(input bit key, output exp_t e);
    bit k_seen = m_d2;
    bit lng    = 1'b0;
    bit prs    = 1'b0;
    bit rls    = 1'b0;
    m_d2 = m_d1;
    m_d1 = key;
    if (m_level && m_held < H) begin
      m_held++;
      if (m_held == H) lng = 1'b1;
    end
    if ((!k_seen) != m_level) m_run++;
    else m_run = 0;
    if (m_run == D) begin
      m_level = !m_level;
      m_run   = 0;
      m_held  = 0;
      if (m_level) begin
        prs      = 1'b1;
        m_toggle = !m_toggle;
      end else begin
        rls = 1'b1;
      end
    end
    e.cyc = cyc;
    e.vec = {m_level, m_toggle, prs, rls, lng};
  endfunction

  task automatic step(input bit k);
    exp_t e;
    cyc++;
    KEY = k;
    model_edge(k, e);
    @(posedge CLOCK_50);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic drive(input bit k, input int n);
    repeat (n) step(k);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    #1;
    reset = 1'b1;
    #1;
    check("reset_outputs_clear",
          32'({pressed, toggle, press_pulse, release_pulse, long_press}), 32'd0);
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("outputs@cyc%0d", e.cyc),
              32'({pressed, toggle, press_pulse, release_pulse, long_press}), 32'(e.vec));
        if (press_pulse) begin
          n_press++;
          last_press_cyc = e.cyc;
          toggle_log.push_back(toggle);
        end
        if (release_pulse) begin
          n_release++;
          last_release_cyc = e.cyc;
        end
        if (long_press) begin
          n_long++;
          last_long_cyc = e.cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, p0, r0, l0, t0, done, len;
    bit lvl, rst_done;

    model_reset();
    do_reset();
    drive(1'b1, 9);

    // Clean press then clean release.
    base = cyc + 1;
    drive(1'b0, 15);
    check("clean_press_cycle", 32'(last_press_cyc), 32'(base + 1 + D));
    check("clean_press_count", 32'(n_press), 32'd1);
    check("clean_pressed_level", 32'(pressed), 32'd1);
    check("clean_toggle_level", 32'(toggle), 32'd1);
    drive(1'b1, 10);
    check("clean_release_cycle", 32'(last_release_cyc), 32'(base + 15 + 1 + D));

    // Press with bounce: low 3, high 1, then steady low.
    p0 = n_press;
    drive(1'b0, 3);
    drive(1'b1, 1);
    base = cyc + 1;
    drive(1'b0, 12);
    check("bounce_press_cycle", 32'(last_press_cyc), 32'(base + 1 + D));
    check("bounce_press_count", 32'(n_press - p0), 32'd1);

    // Release with bounce: high 2, low 1, then steady high.
    r0 = n_release;
    drive(1'b1, 2);
    drive(1'b0, 1);
    base = cyc + 1;
    drive(1'b1, 10);
    check("bounce_release_cycle", 32'(last_release_cyc), 32'(base + 1 + D));
    check("bounce_release_count", 32'(n_release - r0), 32'd1);
    check("bounce_released_level", 32'(pressed), 32'd0);

    // Long press fires exactly once, H cycles after the press strobe.
    l0 = n_long;
    drive(1'b0, 40);
    drive(1'b1, 10);
    check("long_press_count", 32'(n_long - l0), 32'd1);
    check("long_press_delay", 32'(last_long_cyc - last_press_cyc), 32'(H));

    // Short press produces no long_press.
    l0 = n_long;
    drive(1'b0, 8);
    drive(1'b1, 12);
    check("short_press_no_long", 32'(n_long - l0), 32'd0);

    // Three clean press/release pairs: toggle 1,0,1.
    t0 = toggle_log.size();
    p0 = n_press;
    r0 = n_release;
    repeat (3) begin
      drive(1'b0, 8);
      drive(1'b1, 8);
    end
    check("toggle_pair_count", 32'(toggle_log.size() - t0), 32'd3);
    if (toggle_log.size() - t0 == 3) begin
      check("toggle_seq_0", 32'(toggle_log[t0]), 32'd1);
      check("toggle_seq_1", 32'(toggle_log[t0 + 1]), 32'd0);
      check("toggle_seq_2", 32'(toggle_log[t0 + 2]), 32'd1);
    end
    check("toggle_press_count", 32'(n_press - p0), 32'd3);
    check("toggle_release_count", 32'(n_release - r0), 32'd3);

    // Reset in PRESS_WAIT with KEY held low: full latency from deassertion.
    drive(1'b0, 4);
    do_reset();
    base = cyc;
    drive(1'b0, 10);
    check("reset_repress_cycle", 32'(last_press_cyc), 32'(base + 2 + D));
    drive(1'b1, 10);

    // Randomized bouncy traffic with one asynchronous reset part-way through.
    done     = 0;
    lvl      = 1'b0;
    rst_done = 1'b0;
    while (done < 3000) begin
      if ($urandom_range(0, 3) == 0) len = $urandom_range(8, 35);
      else len = $urandom_range(1, 6);
      drive(lvl, len);
      done += len;
      lvl = !lvl;
      if (!rst_done && done > 1500) begin
        do_reset();
        rst_done = 1'b1;
      end
    end
    drive(1'b1, 12);
    @(negedge CLOCK_50);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
